// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multi-cycle MIPS datapath
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] ALUOp_o,
  output logic       illegal_o,
  output logic       instr_done_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_R   = 3'b110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready_i ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the current state; an asserted reset masks them
  // so an aborted memory access never issues a strobe in the reset cycle.
  always_comb begin
    pc_write_o   = 1'b0;
    pc_src_o     = PCSRC_ALU;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    ALUOp_o      = ALU_ADD;
    illegal_o    = 1'b0;
    instr_done_o = 1'b0;
    if (rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b_o = SRCB_IMM4;
          case (opcode_i)
            OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J: illegal_o = 1'b0;
            default: illegal_o = 1'b1;
          endcase
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          ALUOp_o     = ALU_R;
        end
        S_WB_R: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 1'b1;
          instr_done_o = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
          ALUOp_o     = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_WB_I: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_WB_MEM: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEM_WR: begin
          mem_write_o  = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_BRANCH: begin
          alu_src_a_o  = 1'b1;
          ALUOp_o      = ALU_SUB;
          pc_src_o     = PCSRC_ALUOUT;
          pc_write_o   = zero_i;
          instr_done_o = 1'b1;
        end
        S_JUMP: begin
          pc_src_o     = PCSRC_JUMP;
          pc_write_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        default: begin
          pc_write_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic       instr_done;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       zero;
    logic [5:0] op;
    outs_t      exp;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_i, zero_i, mem_ready_i;
  logic [5:0] opcode_i;
  logic       pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, illegal_o, instr_done_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] ALUOp_o;
  outs_t      act;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .ir_write_o(ir_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .ALUOp_o(ALUOp_o), .illegal_o(illegal_o), .instr_done_o(instr_done_o)
  );

  assign act = {pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
                reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                ALUOp_o, illegal_o, instr_done_o};

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int popped = 0;
  cyc_t plan[$];
  outs_t exp_q[$];
  logic [5:0] cur_op = OP_R;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op == OP_R || op == OP_ADDI || op == OP_SLTI || op == OP_BEQ ||
           op == OP_LW || op == OP_SW || op == OP_J;
  endfunction

  task automatic add(input logic rst, input logic rdy, input logic zero, input outs_t e);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.zero = zero; c.op = cur_op; c.exp = e;
    plan.push_back(c);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) add(1'b0, rnd(), rnd(), '0);
    add(1'b1, rnd(), rnd(), '0);
  endtask

  // Fetch phase: request held for every wait cycle, IR/PC load only on ready.
  task automatic add_fetch(input int fw);
    outs_t e;
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    for (int i = 0; i < fw; i++) add(1'b1, 1'b0, rnd(), e);
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    add(1'b1, 1'b1, rnd(), e);
  endtask

  task automatic add_decode(input logic [5:0] op);
    outs_t e;
    cur_op = op;
    e = '0; e.alu_src_b = 2'b11; e.illegal = !legal(op);
    add(1'b1, rnd(), rnd(), e);
  endtask

  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    outs_t e;
    add_fetch(fw);
    add_decode(op);
    if (!legal(op)) return;
    e = '0;
    if (op == OP_R) begin
      e.alu_src_a = 1'b1; e.alu_op = 3'b110; add(1'b1, rnd(), rnd(), e);
      e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
      add(1'b1, rnd(), rnd(), e);
    end else if (op == OP_ADDI || op == OP_SLTI) begin
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      e.alu_op = (op == OP_SLTI) ? 3'b101 : 3'b000;
      add(1'b1, rnd(), rnd(), e);
      e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1;
      add(1'b1, rnd(), rnd(), e);
    end else if (op == OP_LW || op == OP_SW) begin
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; add(1'b1, rnd(), rnd(), e);
      e = '0; e.iord = 1'b1; e.mem_read = (op == OP_LW); e.mem_write = (op == OP_SW);
      for (int i = 0; i < mw; i++) add(1'b1, 1'b0, rnd(), e);
      e.instr_done = (op == OP_SW);
      add(1'b1, 1'b1, rnd(), e);
      if (op == OP_LW) begin
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
        add(1'b1, rnd(), rnd(), e);
      end
    end else if (op == OP_BEQ) begin
      e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01;
      e.pc_write = z; e.instr_done = 1'b1;
      add(1'b1, rnd(), z, e);
    end else begin
      e.pc_src = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1;
      add(1'b1, rnd(), rnd(), e);
    end
  endtask

  // sw whose write wait is cut short by reset after k wait cycles.
  task automatic add_sw_abort(input int fw, input int k);
    outs_t e;
    add_fetch(fw);
    add_decode(OP_SW);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; add(1'b1, rnd(), rnd(), e);
    e = '0; e.iord = 1'b1; e.mem_write = 1'b1;
    for (int i = 0; i < k; i++) add(1'b1, 1'b0, rnd(), e);
    add_reset(1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      e = exp_q.pop_front();
      popped++;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL outputs cycle=%0d actual=%h required=%h", popped, act, e);
      end
    end
  end

  initial begin
    logic [5:0] ops [7];
    ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_SLTI; ops[3] = OP_BEQ;
    ops[4] = OP_LW; ops[5] = OP_SW; ops[6] = OP_J;
    rst_i = 1'b0; mem_ready_i = 1'b0; zero_i = 1'b0; opcode_i = OP_R;

    add_reset(2);
    add_instr(OP_R, 0, 0, 1'b0);
    add_instr(OP_LW, 2, 3, 1'b0);
    add_instr(OP_BEQ, 0, 0, 1'b1);
    add_instr(OP_BEQ, 1, 0, 1'b0);
    add_instr(OP_SLTI, 0, 0, 1'b0);
    add_instr(OP_ADDI, 0, 0, 1'b0);
    add_instr(6'b111111, 0, 0, 1'b0);
    add_instr(OP_J, 0, 0, 1'b0);
    add_instr(OP_SW, 0, 2, 1'b0);
    add_sw_abort(1, 2);
    add_instr(OP_R, 0, 0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 19) == 0) add_sw_abort($urandom_range(0, 2), $urandom_range(0, 2));
      else add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rnd());
    end

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      rst_i = plan[i].rst;
      mem_ready_i = plan[i].rdy;
      zero_i = plan[i].zero;
      opcode_i = plan[i].op;
      exp_q.push_back(plan[i].exp);
      pushed++;
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || popped != pushed) begin
      failures++;
      $display("FAIL drain actual_popped=%0d required=%0d", popped, pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multi-cycle MIPS datapath. Decodes the instruction opcode and sequences fetch, decode, execute, memory and write-back over several cycles. Per state, drives the PC, IR, memory, register-file and ALU-source strobes and the 3-bit ALUOp consumed by the ALU controller. Stalls on a memory ready handshake so that memories with variable latency are supported.

## Interface
- No parameters.
- clk_i  input  1  rising-edge clock
- rst_i  input  1  synchronous reset, active-low
- opcode_i  input  6  IR[31:26]; stable from DECODE until the next FETCH completes
- zero_i  input  1  ALU zero flag
- mem_ready_i  input  1  memory completes the current access this cycle
- pc_write_o  output  1  load PC
- pc_src_o  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
- ir_write_o  output  1  load IR
- iord_o  output  1  memory address source: 0 PC, 1 ALUOut
- mem_read_o  output  1  memory read request
- mem_write_o  output  1  memory write request
- reg_write_o  output  1  register-file write enable
- reg_dst_o  output  1  destination register: 0 rt, 1 rd
- mem_to_reg_o  output  1  write-back data: 0 ALUOut, 1 MDR
- alu_src_a_o  output  1  ALU operand A: 0 PC, 1 A register
- alu_src_b_o  output  2  ALU operand B: 00 B register, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- ALUOp_o  output  3  000 add, 001 subtract, 101 set-less-than, 110 R-type (use funct)
- illegal_o  output  1  one-cycle pulse: unknown opcode
- instr_done_o  output  1  one-cycle pulse: instruction retired

## Operation
- Opcodes:
  - R-type 000000
  - addi 001000
  - slti 001010
  - beq 000100
  - lw 100011
  - sw 101011
  - j 000010
  - all other opcodes are illegal.
- Default value of every output is 0 in every state unless listed below.
- States, strobes and transitions:
  - IDLE: no strobes. Always -> FETCH.
  - FETCH: mem_read=1, iord=0, src_a=0, src_b=01, ALUOp=000. While mem_ready_i=0, stay. When mem_ready_i=1 (same cycle): ir_write=1, pc_write=1, pc_src=00, then -> DECODE.
  - DECODE: src_a=0, src_b=11, ALUOp=000 (branch target into ALUOut). Next state by opcode:
    - R-type -> EXEC_R
    - addi or slti -> EXEC_I
    - lw or sw -> MEM_ADDR
    - beq -> BRANCH
    - j -> JUMP
    - illegal -> FETCH, with illegal_o=1 this cycle.
  - EXEC_R: src_a=1, src_b=00, ALUOp=110. -> WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
  - EXEC_I: src_a=1, src_b=10. ALUOp=000 for addi, 101 for slti. -> WB_I.
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
  - MEM_ADDR: src_a=1, src_b=10, ALUOp=000. lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD: mem_read=1, iord=1. Stay while mem_ready_i=0; otherwise -> WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
  - MEM_WR: mem_write=1, iord=1. Stay while mem_ready_i=0; otherwise -> FETCH.
  - BRANCH: src_a=1, src_b=00, ALUOp=001, pc_src=01, pc_write=zero_i. -> FETCH.
  - JUMP: pc_src=10, pc_write=1. -> FETCH.
- instr_done_o=1 in the final cycle of each legal instruction, i.e. the cycle whose next state is FETCH. It is never asserted on the illegal path.
- Memory request stability: mem_read_o/mem_write_o and iord_o are held constant throughout a wait.

## Timing
- State register updates on the rising edge of clk_i. Outputs are combinational from the state, plus mem_ready_i (FETCH) and zero_i (BRANCH).
- Reset:
  - rst_i=0 at a rising edge -> state becomes IDLE.
  - While rst_i=0, every output is forced to 0 combinationally, including in the cycle that precedes the edge.
  - Reset mid-wait (MEM_RD, MEM_WR, FETCH) aborts the access; no strobe is issued.
  - The first FETCH occurs one cycle after rst_i returns high.
- Cycles per instruction with zero-wait memory (mem_ready_i=1 on first request):
  - R-type, addi, slti, sw: 4
  - lw: 5
  - beq, j: 3
  - illegal: 2
- Each wait cycle adds exactly 1 cycle per cycle that mem_ready_i=0.
- A mem_ready_i pulse outside FETCH, MEM_RD or MEM_WR is ignored.
- beq: pc_write_o is sampled from zero_i in the BRANCH cycle only.

## Test plan
- Reset, then R-type opcode, mem_ready_i=1 constantly:
  - State sequence IDLE, FETCH, DECODE, EXEC_R, WB_R.
  - ALUOp_o=110 in EXEC_R.
  - reg_write_o=1 and reg_dst_o=1 in WB_R only.
  - instr_done_o pulses once.
- lw, with mem_ready_i low for 2 cycles in FETCH and 3 cycles in MEM_RD:
  - Total 10 cycles.
  - mem_read_o held 1 and iord_o held constant throughout each wait.
  - ir_write_o exactly 1 cycle.
  - WB_MEM shows mem_to_reg_o=1.
- beq, zero_i=1 then zero_i=0 on two consecutive instructions:
  - pc_write_o=1 with pc_src_o=01 in the first BRANCH state.
  - pc_write_o=0 in the second BRANCH state.
  - ALUOp_o=001 in both.
- slti vs addi:
  - EXEC_I shows ALUOp_o=101 for slti and 000 for addi.
  - WB_I shows reg_dst_o=0.
- Opcode 111111:
  - illegal_o=1 in the DECODE cycle, then FETCH.
  - No reg_write_o, mem_write_o or instr_done_o.
- sw with rst_i driven low during a MEM_WR wait:
  - All outputs 0 in that same cycle.
  - Next state IDLE, then FETCH.
  - No mem_write_o after reset releases.
